// File: rtl/wb_multiport_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_multiport_arbiter_if
// Bundle of every bus-side signal of the multiport Wishbone arbiter.
//   - wb_*_i / wb_*_o : PORTS packed Wishbone slave ports (port p at slice p)
//   - mem_*           : single request interface towards the memory controller
//   - grant_o         : one-hot registered grant
//   - snp_*           : registered write-snoop broadcast
// Modport "slave" is the arbiter's view; "master" is the view of the
// surrounding logic (bus masters plus memory controller).
// ---------------------------------------------------------------------------
interface wb_multiport_arbiter_if #(
  parameter int PORTS = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
) ();
  localparam int SW = DW / 8;

  logic [PORTS*AW-1:0] wb_adr_i;
  logic [PORTS*DW-1:0] wb_dat_i;
  logic [PORTS*SW-1:0] wb_sel_i;
  logic [PORTS-1:0]    wb_we_i;
  logic [PORTS-1:0]    wb_cyc_i;
  logic [PORTS-1:0]    wb_stb_i;
  logic [PORTS*3-1:0]  wb_cti_i;
  logic [PORTS*DW-1:0] wb_dat_o;
  logic [PORTS-1:0]    wb_ack_o;

  logic                mem_req_o;
  logic [AW-1:0]       mem_adr_o;
  logic [DW-1:0]       mem_dat_o;
  logic [SW-1:0]       mem_sel_o;
  logic                mem_we_o;
  logic [2:0]          mem_cti_o;
  logic [DW-1:0]       mem_dat_i;
  logic                mem_ack_i;

  logic [PORTS-1:0]    grant_o;

  logic                snp_vld_o;
  logic [2:0]          snp_port_o;
  logic [AW-1:0]       snp_adr_o;
  logic [DW-1:0]       snp_dat_o;
  logic [SW-1:0]       snp_sel_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i,
    output wb_dat_o, wb_ack_o,
    output mem_req_o, mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_cti_o,
    input  mem_dat_i, mem_ack_i,
    output grant_o,
    output snp_vld_o, snp_port_o, snp_adr_o, snp_dat_o, snp_sel_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i,
    input  wb_dat_o, wb_ack_o,
    input  mem_req_o, mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_cti_o,
    output mem_dat_i, mem_ack_i,
    input  grant_o,
    input  snp_vld_o, snp_port_o, snp_adr_o, snp_dat_o, snp_sel_o
  );
endinterface

// File: rtl/wb_multiport_arbiter.sv
// ---------------------------------------------------------------------------
// wb_multiport_arbiter
// Multiplexes PORTS Wishbone masters onto one memory-controller request
// interface. Round-robin or fixed-priority arbitration, a per-grant burst
// cap that forces rotation when others wait, bus lock while cyc stays high,
// and a registered write-snoop broadcast of every acked write beat.
// Ports:
//   wb_clk   - clock, all logic on the rising edge
//   wb_rst_n - asynchronous active-low reset
//   bus      - wb_multiport_arbiter_if.slave (Wishbone ports, memory side,
//              grant and snoop outputs)
// ---------------------------------------------------------------------------
module wb_multiport_arbiter #(
  parameter int PORTS     = 4,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int ARB_MODE  = 0,
  parameter int MAX_BURST = 8
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  wb_multiport_arbiter_if.slave  bus
);
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic [PORTS-1:0] r_grant;
  logic [2:0]       r_gidx;
  logic [2:0]       r_ptr;
  logic [7:0]       r_beats;
  logic             r_snpVld;
  logic [2:0]       r_snpPort;
  logic [AW-1:0]    r_snpAdr;
  logic [DW-1:0]    r_snpDat;
  logic [SW-1:0]    r_snpSel;

  logic [PORTS-1:0]   w_req;
  logic [2*PORTS-1:0] w_dbl;
  logic [3:0]         w_sum;
  logic               w_found;
  logic [2:0]         w_winIdx;
  logic [PORTS-1:0]   w_winOh;
  logic [AW-1:0]      w_adr;
  logic [DW-1:0]      w_dat;
  logic [SW-1:0]      w_sel;
  logic               w_we;
  logic [2:0]         w_cti;
  logic               w_gcyc;
  logic               w_memReq;
  logic               w_beat;
  logic [PORTS-1:0]   w_ack;
  logic               w_others;
  logic               w_last;
  logic               w_capHit;
  logic               w_release;
  logic               w_snpHit;

  assign w_req = bus.wb_cyc_i & bus.wb_stb_i;

  // Winner selection. Round-robin rotates a doubled request vector so the
  // port after the pointer lands at bit 0; the first set bit then maps back
  // to a port index modulo PORTS. Fixed priority takes the lowest requester.
  always_comb begin
    w_winIdx = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_dbl    = {w_req, w_req} >> ({1'b0, r_ptr} + 4'd1);
    if (ARB_MODE == 1) begin
      for (int k = PORTS - 1; k >= 0; k--) begin
        if (w_req[k]) w_winIdx = 3'(k);
      end
    end else begin
      for (int k = 0; k < PORTS; k++) begin
        if (!w_found && w_dbl[k]) begin
          w_found = 1'b1;
          w_sum   = {1'b0, r_ptr} + 4'd1 + 4'(k);
          if (w_sum >= 4'(PORTS)) w_sum = w_sum - 4'(PORTS);
          w_winIdx = w_sum[2:0];
        end
      end
    end
    w_winOh = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_winOh[p] = (w_winIdx == 3'(p));
    end
  end

  // Granted-port field mux; an all-zero grant yields all-zero fields.
  always_comb begin
    w_adr  = '0;
    w_dat  = '0;
    w_sel  = '0;
    w_we   = 1'b0;
    w_cti  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (r_grant[p]) begin
        w_adr = w_adr | bus.wb_adr_i[p*AW +: AW];
        w_dat = w_dat | bus.wb_dat_i[p*DW +: DW];
        w_sel = w_sel | bus.wb_sel_i[p*SW +: SW];
        w_we  = w_we  | bus.wb_we_i[p];
        w_cti = w_cti | bus.wb_cti_i[p*3 +: 3];
      end
    end
  end

  assign w_gcyc   = |(r_grant & bus.wb_cyc_i);
  assign w_memReq = (r_state == BUSY) && |(r_grant & w_req);
  assign w_beat   = bus.mem_ack_i & w_memReq;
  assign w_ack    = r_grant & {PORTS{w_beat}};
  assign w_others = |(w_req & ~r_grant);
  assign w_last   = w_beat && ((w_cti == 3'b000) || (w_cti == 3'b111));
  // Saturated counter keeps this true, so a late competitor still forces a
  // release on the next beat.
  assign w_capHit = w_beat && w_others &&
                    (({1'b0, r_beats} + 9'd1) >= 9'(MAX_BURST));
  assign w_release = !w_gcyc || w_last || w_capHit;
  assign w_snpHit  = |(w_ack & bus.wb_we_i);

  assign bus.wb_dat_o  = {PORTS{bus.mem_dat_i}};
  assign bus.wb_ack_o  = w_ack;
  assign bus.mem_req_o = w_memReq;
  assign bus.mem_adr_o = w_adr;
  assign bus.mem_dat_o = w_dat;
  assign bus.mem_sel_o = w_sel;
  assign bus.mem_we_o  = w_we;
  assign bus.mem_cti_o = w_cti;
  assign bus.grant_o   = r_grant;
  assign bus.snp_vld_o  = r_snpVld;
  assign bus.snp_port_o = r_snpPort;
  assign bus.snp_adr_o  = r_snpAdr;
  assign bus.snp_dat_o  = r_snpDat;
  assign bus.snp_sel_o  = r_snpSel;

  // Arbitration FSM plus snoop capture. The pointer resets to the last port
  // so port 0 wins the first round-robin decision.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= 3'(PORTS - 1);
      r_beats   <= '0;
      r_snpVld  <= 1'b0;
      r_snpPort <= '0;
      r_snpAdr  <= '0;
      r_snpDat  <= '0;
      r_snpSel  <= '0;
    end else begin
      r_snpVld <= w_snpHit;
      if (w_snpHit) begin
        r_snpPort <= r_gidx;
        r_snpAdr  <= w_adr;
        r_snpDat  <= w_dat;
        r_snpSel  <= w_sel;
      end
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state <= BUSY;
            r_grant <= w_winOh;
            r_gidx  <= w_winIdx;
            r_beats <= '0;
            if (ARB_MODE == 0) r_ptr <= w_winIdx;
          end
        end
        BUSY: begin
          if (w_beat && (r_beats < 8'(MAX_BURST))) r_beats <= r_beats + 8'd1;
          if (w_release) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_multiport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_multiport_arbiter
// Directed bench for wb_multiport_arbiter. Two instances: a round-robin one
// and a fixed-priority one, both four ports of 32 bits with MAX_BURST = 4.
// The memory side always acknowledges.
// ---------------------------------------------------------------------------
module tb_wb_multiport_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wb_multiport_arbiter_if #(.PORTS(4), .DW(32), .AW(32)) rrBus ();
  wb_multiport_arbiter_if #(.PORTS(4), .DW(32), .AW(32)) fpBus ();

  wb_multiport_arbiter #(
    .PORTS(4), .DW(32), .AW(32), .ARB_MODE(0), .MAX_BURST(4)
  ) dutRr (
    .wb_clk  (clk),
    .wb_rst_n(rst_n),
    .bus     (rrBus.slave)
  );

  wb_multiport_arbiter #(
    .PORTS(4), .DW(32), .AW(32), .ARB_MODE(1), .MAX_BURST(4)
  ) dutFp (
    .wb_clk  (clk),
    .wb_rst_n(rst_n),
    .bus     (fpBus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-port master model state for the round-robin instance
  int          beatsLeft[4];
  int          beatsDone[4];
  bit          burstP[4];
  bit          weP[4];
  logic [31:0] baseAdr[4];
  int          ackLog[$];
  int          ackCyc[$];

  task automatic clearInputs();
    rrBus.wb_adr_i = '0; rrBus.wb_dat_i = '0; rrBus.wb_sel_i = '0;
    rrBus.wb_we_i  = '0; rrBus.wb_cyc_i = '0; rrBus.wb_stb_i = '0;
    rrBus.wb_cti_i = '0;
    fpBus.wb_adr_i = '0; fpBus.wb_dat_i = '0; fpBus.wb_sel_i = '0;
    fpBus.wb_we_i  = '0; fpBus.wb_cyc_i = '0; fpBus.wb_stb_i = '0;
    fpBus.wb_cti_i = '0;
    rrBus.mem_ack_i = 1'b1; rrBus.mem_dat_i = 32'hCAFE0000;
    fpBus.mem_ack_i = 1'b1; fpBus.mem_dat_i = 32'hCAFE0000;
    for (int p = 0; p < 4; p++) begin
      beatsLeft[p] = 0; beatsDone[p] = 0; burstP[p] = 1'b0; weP[p] = 1'b0;
      baseAdr[p] = 32'h1000 * (p + 1);
    end
    ackLog.delete();
    ackCyc.delete();
  endtask

  // Leaves the bench at posedge+1 with reset released and inputs idle
  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic driveMasters();
    bit act;
    for (int p = 0; p < 4; p++) begin
      act = (beatsLeft[p] > 0);
      rrBus.wb_cyc_i[p] = act;
      rrBus.wb_stb_i[p] = act;
      rrBus.wb_we_i[p]  = weP[p] & act;
      rrBus.wb_adr_i[p*32 +: 32] = baseAdr[p] + 32'(4 * beatsDone[p]);
      rrBus.wb_dat_i[p*32 +: 32] = baseAdr[p] ^ 32'(beatsDone[p]);
      rrBus.wb_sel_i[p*4 +: 4]   = 4'hF;
      rrBus.wb_cti_i[p*3 +: 3]   = !burstP[p] ? 3'b000 :
                                   (beatsLeft[p] == 1 ? 3'b111 : 3'b010);
    end
  endtask

  // Runs the master model until all beats are acked or the budget expires
  task automatic runMasters(input int maxCycles, output bit done);
    int left;
    done = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      driveMasters();
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        if (rrBus.wb_ack_o[p]) begin
          ackLog.push_back(p);
          ackCyc.push_back(c);
          beatsDone[p]++;
          if (beatsLeft[p] > 0) beatsLeft[p]--;
        end
      end
      @(posedge clk);
      #1;
      left = 0;
      for (int p = 0; p < 4; p++) left += beatsLeft[p];
      if (left == 0) begin
        done = 1'b1;
        break;
      end
    end
    driveMasters();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    rrBus.wb_cyc_i[0] = 1'b1;
    rrBus.wb_stb_i[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rrBus.grant_o !== 4'b0000) begin errors++;
      $display("[TB] FAIL reset_grant: got %b expected 0000", rrBus.grant_o); end
    checks++; if (rrBus.mem_req_o !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_mem_req: got %b expected 0", rrBus.mem_req_o); end
    checks++; if (rrBus.wb_ack_o !== 4'b0000) begin errors++;
      $display("[TB] FAIL reset_ack: got %b expected 0000", rrBus.wb_ack_o); end
    checks++; if (rrBus.mem_adr_o !== 32'h0) begin errors++;
      $display("[TB] FAIL reset_mem_adr: got %h expected 0", rrBus.mem_adr_o); end
    checks++; if ({rrBus.snp_vld_o, rrBus.snp_port_o, rrBus.snp_adr_o} !== 36'h0) begin errors++;
      $display("[TB] FAIL reset_snoop: got %b/%0d/%h expected 0/0/0",
               rrBus.snp_vld_o, rrBus.snp_port_o, rrBus.snp_adr_o); end
  endtask

  task automatic test_single_port();
    doReset();
    rrBus.wb_cyc_i[2] = 1'b1; rrBus.wb_stb_i[2] = 1'b1; rrBus.wb_we_i[2] = 1'b1;
    rrBus.wb_adr_i[64 +: 32] = 32'h100;
    rrBus.wb_dat_i[64 +: 32] = 32'hDEADBEEF;
    rrBus.wb_sel_i[8 +: 4]   = 4'hF;
    rrBus.wb_cti_i[6 +: 3]   = 3'b000;
    @(negedge clk);
    checks++; if ({rrBus.grant_o, rrBus.wb_ack_o, rrBus.mem_req_o} !== 9'h0) begin errors++;
      $display("[TB] FAIL single_idle: grant %b ack %b req %b expected all 0",
               rrBus.grant_o, rrBus.wb_ack_o, rrBus.mem_req_o); end
    @(negedge clk);
    checks++; if (rrBus.grant_o !== 4'b0100) begin errors++;
      $display("[TB] FAIL single_grant: got %b expected 0100", rrBus.grant_o); end
    checks++; if (rrBus.wb_ack_o !== 4'b0100) begin errors++;
      $display("[TB] FAIL single_ack: got %b expected 0100", rrBus.wb_ack_o); end
    checks++; if ({rrBus.mem_req_o, rrBus.mem_we_o, rrBus.mem_adr_o, rrBus.mem_dat_o}
                  !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin errors++;
      $display("[TB] FAIL single_mem_fields: got req %b we %b adr %h dat %h expected 1 1 100 deadbeef",
               rrBus.mem_req_o, rrBus.mem_we_o, rrBus.mem_adr_o, rrBus.mem_dat_o); end
    checks++; if (rrBus.wb_dat_o[64 +: 32] !== 32'hCAFE0000) begin errors++;
      $display("[TB] FAIL single_rdata: got %h expected cafe0000", rrBus.wb_dat_o[64 +: 32]); end
    @(posedge clk);
    #1;
    rrBus.wb_cyc_i[2] = 1'b0; rrBus.wb_stb_i[2] = 1'b0; rrBus.wb_we_i[2] = 1'b0;
    @(negedge clk);
    checks++; if (rrBus.grant_o !== 4'b0000) begin errors++;
      $display("[TB] FAIL single_release: got %b expected 0000", rrBus.grant_o); end
    checks++; if ({rrBus.snp_vld_o, rrBus.snp_port_o, rrBus.snp_adr_o, rrBus.snp_dat_o, rrBus.snp_sel_o}
                  !== {1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 4'hF}) begin errors++;
      $display("[TB] FAIL single_snoop: got vld %b port %0d adr %h dat %h sel %h expected 1 2 100 deadbeef f",
               rrBus.snp_vld_o, rrBus.snp_port_o, rrBus.snp_adr_o, rrBus.snp_dat_o, rrBus.snp_sel_o); end
    @(negedge clk);
    checks++; if ({rrBus.snp_vld_o, rrBus.snp_adr_o} !== {1'b0, 32'h100}) begin errors++;
      $display("[TB] FAIL single_snoop_hold: got vld %b adr %h expected 0 100",
               rrBus.snp_vld_o, rrBus.snp_adr_o); end
  endtask

  task automatic test_rr_fairness();
    int expOrder[6] = '{0, 1, 3, 0, 1, 3};
    int got;
    bit done;
    doReset();
    beatsLeft[0] = 2; beatsLeft[1] = 2; beatsLeft[3] = 2;
    runMasters(40, done);
    checks++; if (done !== 1'b1) begin errors++;
      $display("[TB] FAIL rr_timeout: got done %b expected 1", done); end
    checks++; if (ackLog.size() !== 6) begin errors++;
      $display("[TB] FAIL rr_count: got %0d acks expected 6", ackLog.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < ackLog.size()) ? ackLog[i] : -1;
      checks++; if (got !== expOrder[i]) begin errors++;
        $display("[TB] FAIL rr_order[%0d]: got port %0d expected port %0d", i, got, expOrder[i]); end
    end
  endtask

  task automatic test_fixed_priority();
    int  n1;
    bit  sawP3;
    bit  found;
    doReset();
    fpBus.wb_cyc_i = 4'b1010;
    fpBus.wb_stb_i = 4'b1010;
    n1 = 0;
    sawP3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fpBus.grant_o == 4'b1000) sawP3 = 1'b1;
      if (fpBus.grant_o == 4'b0010) n1++;
    end
    checks++; if (n1 !== 4) begin errors++;
      $display("[TB] FAIL fp_port1_grants: got %0d expected 4", n1); end
    checks++; if (sawP3 !== 1'b0) begin errors++;
      $display("[TB] FAIL fp_port3_early: got %b expected 0", sawP3); end
    @(posedge clk);
    #1;
    fpBus.wb_cyc_i[1] = 1'b0;
    fpBus.wb_stb_i[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fpBus.grant_o == 4'b1000) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++;
      $display("[TB] FAIL fp_port3_grant: got %b expected 1000 within 4 cycles", fpBus.grant_o); end
    checks++; if (fpBus.wb_ack_o !== 4'b1000) begin errors++;
      $display("[TB] FAIL fp_port3_ack: got %b expected 1000", fpBus.wb_ack_o); end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic test_burst_cap();
    int expLog[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int got;
    bit done;
    doReset();
    beatsLeft[0] = 8; burstP[0] = 1'b1;
    beatsLeft[1] = 1;
    runMasters(40, done);
    checks++; if (done !== 1'b1) begin errors++;
      $display("[TB] FAIL cap_timeout: got done %b expected 1", done); end
    checks++; if (ackLog.size() !== 9) begin errors++;
      $display("[TB] FAIL cap_count: got %0d acks expected 9", ackLog.size()); end
    for (int i = 0; i < 9; i++) begin
      got = (i < ackLog.size()) ? ackLog[i] : -1;
      checks++; if (got !== expLog[i]) begin errors++;
        $display("[TB] FAIL cap_order[%0d]: got port %0d expected port %0d", i, got, expLog[i]); end
    end
  endtask

  task automatic test_burst_alone();
    int span;
    bit done;
    doReset();
    beatsLeft[0] = 8; burstP[0] = 1'b1;
    runMasters(30, done);
    checks++; if ((done !== 1'b1) || (ackLog.size() !== 8)) begin errors++;
      $display("[TB] FAIL alone_count: got done %b acks %0d expected 1 8", done, ackLog.size()); end
    span = (ackCyc.size() == 8) ? (ackCyc[7] - ackCyc[0]) : -1;
    checks++; if (span !== 7) begin errors++;
      $display("[TB] FAIL alone_contiguous: got span %0d expected 7", span); end
  endtask

  task automatic test_lock();
    bit found;
    doReset();
    rrBus.wb_cyc_i = 4'b0011;
    rrBus.wb_stb_i = 4'b0011;
    rrBus.wb_adr_i[0 +: 32] = 32'h300;
    rrBus.wb_cti_i[0 +: 3]  = 3'b010;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rrBus.wb_ack_o !== 4'b0001) begin errors++;
      $display("[TB] FAIL lock_first_beat: got %b expected 0001", rrBus.wb_ack_o); end
    @(posedge clk);
    #1;
    rrBus.wb_stb_i[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({rrBus.grant_o, rrBus.wb_ack_o, rrBus.mem_req_o} !== {4'b0001, 4'b0000, 1'b0}) begin errors++;
        $display("[TB] FAIL lock_hold[%0d]: got grant %b ack %b req %b expected 0001 0000 0",
                 i, rrBus.grant_o, rrBus.wb_ack_o, rrBus.mem_req_o); end
    end
    @(posedge clk);
    #1;
    rrBus.wb_cyc_i[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rrBus.grant_o == 4'b0010) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++;
      $display("[TB] FAIL lock_handover: got %b expected 0010 within 4 cycles", rrBus.grant_o); end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic test_async_reset();
    doReset();
    rrBus.wb_cyc_i = 4'b0011;
    rrBus.wb_stb_i = 4'b0011;
    rrBus.wb_we_i  = 4'b0001;
    rrBus.wb_adr_i[0 +: 32] = 32'h400;
    rrBus.wb_dat_i[0 +: 32] = 32'h11;
    rrBus.wb_sel_i[0 +: 4]  = 4'hF;
    rrBus.wb_cti_i[0 +: 3]  = 3'b010;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rrBus.wb_adr_i[0 +: 32] = 32'h404;
    @(negedge clk);
    checks++; if ({rrBus.wb_ack_o, rrBus.snp_vld_o, rrBus.snp_adr_o} !== {4'b0001, 1'b1, 32'h400}) begin errors++;
      $display("[TB] FAIL areset_beat2: got ack %b vld %b adr %h expected 0001 1 400",
               rrBus.wb_ack_o, rrBus.snp_vld_o, rrBus.snp_adr_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rrBus.grant_o, rrBus.mem_req_o, rrBus.wb_ack_o, rrBus.snp_vld_o} !== 10'h0) begin errors++;
      $display("[TB] FAIL areset_outputs: got grant %b req %b ack %b vld %b expected all 0",
               rrBus.grant_o, rrBus.mem_req_o, rrBus.wb_ack_o, rrBus.snp_vld_o); end
    checks++; if (rrBus.snp_adr_o !== 32'h0) begin errors++;
      $display("[TB] FAIL areset_snoop_adr: got %h expected 0", rrBus.snp_adr_o); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rrBus.grant_o !== 4'b0001) begin errors++;
      $display("[TB] FAIL areset_first_rr: got %b expected 0001", rrBus.grant_o); end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clearInputs();
    $display("[TB] starting wb_multiport_arbiter bench");
    test_reset();
    test_single_port();
    test_rr_fairness();
    test_fixed_priority();
    test_burst_cap();
    test_burst_alone();
    test_lock();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
